// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding, load-use
// hazard detection, and hold/flush/bubble control for the ALU stage.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [DW-1:0] id_rdata1,
    input  logic [DW-1:0] id_rdata2,
    input  logic [DW-1:0] id_imm,
    input  logic          id_alu_src,
    input  logic [2:0]    id_ALUop,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_mem_to_reg,
    input  logic          ex_hold,
    input  logic          flush,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_data,
    output logic          id_stall,
    output logic [DW-1:0] reg1,
    output logic [DW-1:0] reg2,
    output logic [2:0]    ALUop,
    output logic [DW-1:0] store_data,
    output logic          ex_valid,
    output logic [RW-1:0] ex_rd,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_mem_to_reg
);

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [DW-1:0] rdata1;
        logic [DW-1:0] rdata2;
        logic [DW-1:0] imm;
        logic          alu_src;
        logic [2:0]    alu_op;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
    } stage_t;

    stage_t st;
    logic   lu;
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;

    // EX/MEM wins over MEM/WB because it holds the younger result; $0 is never forwarded.
    function automatic logic [DW-1:0] fwd(
        input logic [RW-1:0] src,
        input logic [DW-1:0] latched,
        input logic          em_we,
        input logic [RW-1:0] em_rd,
        input logic [DW-1:0] em_val,
        input logic          mw_we,
        input logic [RW-1:0] mw_rd,
        input logic [DW-1:0] mw_val
    );
        if (em_we && em_rd != '0 && em_rd == src)
            return em_val;
        else if (mw_we && mw_rd != '0 && mw_rd == src)
            return mw_val;
        else
            return latched;
    endfunction

    assign lu = st.valid && st.mem_read && (st.rd != '0) && id_valid &&
                ((st.rd == id_rs) || (st.rd == id_rt));
    assign id_stall = lu || ex_hold;

    // NOTE: state registers use non-blocking assignments so every field updates from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st <= '0;
        end else if (ex_hold) begin
            st <= st;
        end else if (flush || lu) begin
            st.valid      <= 1'b0;
            st.reg_write  <= 1'b0;
            st.mem_read   <= 1'b0;
            st.mem_write  <= 1'b0;
            st.mem_to_reg <= 1'b0;
        end else begin
            st.valid      <= id_valid;
            st.rs         <= id_rs;
            st.rt         <= id_rt;
            st.rd         <= id_rd;
            st.rdata1     <= id_rdata1;
            st.rdata2     <= id_rdata2;
            st.imm        <= id_imm;
            st.alu_src    <= id_alu_src;
            st.alu_op     <= id_ALUop;
            st.reg_write  <= id_reg_write;
            st.mem_read   <= id_mem_read;
            st.mem_write  <= id_mem_write;
            st.mem_to_reg <= id_mem_to_reg;
        end
    end

    assign fwd_a = fwd(st.rs, st.rdata1, exmem_reg_write, exmem_rd, exmem_result,
                       memwb_reg_write, memwb_rd, memwb_data);
    assign fwd_b = fwd(st.rt, st.rdata2, exmem_reg_write, exmem_rd, exmem_result,
                       memwb_reg_write, memwb_rd, memwb_data);

    assign reg1          = fwd_a;
    assign store_data    = fwd_b;
    assign reg2          = st.alu_src ? st.imm : fwd_b;
    assign ALUop         = st.alu_op;
    assign ex_valid      = st.valid;
    assign ex_rd         = st.rd;
    assign ex_reg_write  = st.reg_write;
    assign ex_mem_read   = st.mem_read;
    assign ex_mem_write  = st.mem_write;
    assign ex_mem_to_reg = st.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: reset, load, forwarding priority,
// load-use stall, immediate select, and hold/flush ordering.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          id_valid;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic [DW-1:0] id_rdata1, id_rdata2, id_imm;
    logic          id_alu_src;
    logic [2:0]    id_ALUop;
    logic          id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic          ex_hold, flush;
    logic          exmem_reg_write, memwb_reg_write;
    logic [RW-1:0] exmem_rd, memwb_rd;
    logic [DW-1:0] exmem_result, memwb_data;
    logic          id_stall;
    logic [DW-1:0] reg1, reg2, store_data;
    logic [2:0]    ALUop;
    logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [RW-1:0] ex_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_ALUop(id_ALUop),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .ex_hold(ex_hold), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .id_stall(id_stall), .reg1(reg1), .reg2(reg2), .ALUop(ALUop),
        .store_data(store_data), .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic decode(input logic v, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                          input logic [RW-1:0] rd, input logic [DW-1:0] d1,
                          input logic [DW-1:0] d2, input logic [DW-1:0] imm,
                          input logic asrc, input logic [2:0] op, input logic rw,
                          input logic mr, input logic mw, input logic m2r);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rdata1 = d1; id_rdata2 = d2; id_imm = imm; id_alu_src = asrc;
        id_ALUop = op; id_reg_write = rw; id_mem_read = mr;
        id_mem_write = mw; id_mem_to_reg = m2r;
    endtask

    task automatic no_fwd();
        exmem_reg_write = 0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 0; memwb_rd = '0; memwb_data = '0;
    endtask

    initial begin
        reset_n = 0; ex_hold = 0; flush = 0;
        no_fwd();
        decode(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        step(); step();
        check("rst_valid", ex_valid, 0);
        check("rst_aluop", ALUop, 0);
        check("rst_rw", ex_reg_write, 0);
        #2 reset_n = 1;

        // basic load
        decode(1, 3, 4, 2, 5, 7, 0, 0, 3'b010, 1, 0, 1, 0);
        step();
        check("ld_reg1", reg1, 5);
        check("ld_reg2", reg2, 7);
        check("ld_aluop", ALUop, 3'b010);
        check("ld_valid", ex_valid, 1);
        check("ld_rd", ex_rd, 2);
        check("ld_mw", ex_mem_write, 1);
        check("ld_store", store_data, 7);

        // asynchronous reset mid-run takes effect without a clock edge
        #1 reset_n = 0;
        #1;
        check("arst_valid", ex_valid, 0);
        check("arst_aluop", ALUop, 0);
        check("arst_rw", ex_reg_write, 0);
        check("arst_mw", ex_mem_write, 0);
        #1 reset_n = 1;

        // forwarding priority
        decode(1, 8, 0, 1, 32'h33, 0, 0, 0, 3'b001, 1, 0, 0, 0);
        step();
        exmem_reg_write = 1; exmem_rd = 8; exmem_result = 32'h11;
        memwb_reg_write = 1; memwb_rd = 8; memwb_data = 32'h22;
        #1 check("fwd_exmem", reg1, 32'h11);
        exmem_reg_write = 0;
        #1 check("fwd_memwb", reg1, 32'h22);
        memwb_reg_write = 0;
        #1 check("fwd_none", reg1, 32'h33);
        decode(1, 0, 0, 1, 32'h44, 0, 0, 0, 3'b001, 1, 0, 0, 0);
        step();
        exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'h11;
        memwb_reg_write = 1; memwb_rd = 0; memwb_data = 32'h22;
        #1 check("fwd_r0", reg1, 32'h44);
        no_fwd();

        // load-use hazard
        decode(1, 1, 2, 9, 0, 0, 0, 1, 3'b000, 1, 1, 0, 1);
        step();
        check("lw_mr", ex_mem_read, 1);
        decode(1, 9, 5, 10, 0, 3, 0, 0, 3'b000, 1, 0, 0, 0);
        #1 check("lu_stall", id_stall, 1);
        step();
        check("lu_bub_valid", ex_valid, 0);
        check("lu_bub_rw", ex_reg_write, 0);
        check("lu_bub_mr", ex_mem_read, 0);
        check("lu_clear", id_stall, 0);
        step();
        memwb_reg_write = 1; memwb_rd = 9; memwb_data = 32'hAB;
        #1 check("lu_fwd", reg1, 32'hAB);
        check("lu_rd", ex_rd, 10);
        check("lu_valid", ex_valid, 1);
        no_fwd();

        // load into $0 never stalls; match on rt stalls
        decode(1, 1, 2, 0, 0, 0, 0, 1, 3'b000, 1, 1, 0, 1);
        step();
        decode(1, 0, 0, 3, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0);
        #1 check("lu_r0", id_stall, 0);
        decode(1, 1, 2, 4, 0, 0, 0, 1, 3'b000, 1, 1, 0, 1);
        step();
        decode(1, 6, 4, 5, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0);
        #1 check("lu_rt", id_stall, 1);
        step();

        // immediate select with forwarded store data
        decode(1, 0, 6, 7, 0, 1, 32'hFFFF_FFFC, 1, 3'b011, 0, 0, 1, 0);
        step();
        exmem_reg_write = 1; exmem_rd = 6; exmem_result = 32'h55;
        #1 check("imm_reg2", reg2, 32'hFFFF_FFFC);
        check("imm_store", store_data, 32'h55);
        no_fwd();

        // hold beats flush; operands still track forwarding
        decode(1, 11, 0, 12, 32'h77, 0, 0, 0, 3'b101, 1, 0, 0, 0);
        step();
        decode(1, 13, 0, 13, 32'h99, 0, 0, 0, 3'b001, 1, 0, 0, 0);
        ex_hold = 1; flush = 1;
        #1 check("hold_stall", id_stall, 1);
        for (int i = 0; i < 2; i++) begin
            step();
            check("hold_valid", ex_valid, 1);
            check("hold_rd", ex_rd, 12);
            check("hold_aluop", ALUop, 3'b101);
            check("hold_reg1", reg1, 32'h77);
        end
        exmem_reg_write = 1; exmem_rd = 11; exmem_result = 32'h66;
        #1 check("hold_fwd", reg1, 32'h66);
        no_fwd();
        ex_hold = 0;
        #1 check("flush_nostall", id_stall, 0);
        step();
        check("flush_valid", ex_valid, 0);
        check("flush_rw", ex_reg_write, 0);
        flush = 0;
        decode(0, 0, 0, 5, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0);
        step();
        check("idle_valid", ex_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
